fill_r: RTL and testbench



---
 rtl/fill_r.sv | 111 +++++++++++
 tb/tb_fill_r.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fill_r.sv
// Read-fill receiver: pairs each RMISS entry with the next R burst, assembles the
// beats into a cache line and pushes {tid, addr, line} into the FILL FIFO.
module fill_r #(
   parameter int ADDR_W = 64,
   parameter int ID_W   = 16,
   parameter int TID_W  = 10,
   parameter int BEAT_W = 64,
   parameter int BEATS  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ID_W-1:0]                   rid_i,
   input  logic [BEAT_W-1:0]                 rdata_i,
   input  logic [1:0]                        rresp_i,
   input  logic                              rlast_i,
   input  logic                              rvalid_i,
   output logic                              rready_o,
   input  logic                              rmfifo_aempty_i,
   output logic                              rmfifo_rden_o,
   input  logic [TID_W+ADDR_W-1:0]           rmfifo_data_i,
   input  logic                              flfifo_afull_i,
   output logic                              flfifo_wren_o,
   output logic [TID_W+ADDR_W+BEAT_W*BEATS-1:0] flfifo_data_o,
   output logic [2:0]                        err_o
);

   localparam int LINE_W = BEAT_W * BEATS;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_PUSH} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [TID_W-1:0]    tid_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   line_q;
   logic [2:0]          err_q;

   logic beat_hs, cnt_last, burst_end;
   logic resp_err, id_err, len_err;

   function automatic logic [ID_W-1:0] tid_ext(input logic [TID_W-1:0] t);
      logic [ID_W-1:0] r;
      r = '0;
      r[TID_W-1:0] = t;
      return r;
   endfunction

   assign beat_hs   = rvalid_i && (state == S_RECV);
   assign cnt_last  = (cnt == CNT_W'(BEATS - 1));
   // A missing rlast is cut off at the last beat slot; later beats belong to the next burst.
   assign burst_end = beat_hs && (rlast_i || cnt_last);

   assign resp_err = (rresp_i != 2'b00);
   assign id_err   = (rid_i != tid_ext(tid_q));
   assign len_err  = burst_end && (rlast_i != cnt_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!rmfifo_aempty_i) state_nxt = S_RECV;
         S_RECV:  if (burst_end)        state_nxt = S_PUSH;
         S_PUSH:  if (!flfifo_afull_i)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rready_o      = 1'b0;
      rmfifo_rden_o = 1'b0;
      flfifo_wren_o = 1'b0;
      case (state)
         S_IDLE:  rmfifo_rden_o = !rmfifo_aempty_i;
         S_RECV:  rready_o      = 1'b1;
         S_PUSH:  flfifo_wren_o = !flfifo_afull_i;
         default: ;
      endcase
   end

   // Line assembly; unfilled beats stay zero after an early rlast.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         tid_q  <= '0;
         addr_q <= '0;
         line_q <= '0;
         err_q  <= '0;
      end else begin
         if (rmfifo_rden_o) begin
            tid_q  <= rmfifo_data_i[ADDR_W +: TID_W];
            addr_q <= rmfifo_data_i[ADDR_W-1:0];
            line_q <= '0;
            cnt    <= '0;
         end
         if (beat_hs) begin
            line_q[cnt*BEAT_W +: BEAT_W] <= rdata_i;
            cnt   <= cnt + 1'b1;
            err_q <= err_q | {resp_err, id_err, len_err};
         end
      end
   end

   assign flfifo_data_o = {tid_q, addr_q, line_q};
   assign err_o         = err_q;

endmodule

// File: tb/tb_fill_r.sv
// Bench for fill_r: modelled RMISS FIFO and R-beat source, expected fills queued
// at stimulus time and compared when the DUT pushes.
module tb_fill_r;
   localparam int ADDR_W = 64, ID_W = 16, TID_W = 10, BEAT_W = 64, BEATS = 8;
   localparam int LINE_W = BEAT_W * BEATS;
   localparam int FL_W   = TID_W + ADDR_W + LINE_W;

   typedef struct {
      logic [BEAT_W-1:0] d;
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
      logic              last;
   } beat_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [ID_W-1:0] rid_i;
   logic [BEAT_W-1:0] rdata_i;
   logic [1:0] rresp_i;
   logic rlast_i, rvalid_i, rready_o;
   logic rmfifo_aempty_i, rmfifo_rden_o;
   logic [TID_W+ADDR_W-1:0] rmfifo_data_i;
   logic flfifo_afull_i, flfifo_wren_o;
   logic [FL_W-1:0] flfifo_data_o;
   logic [2:0] err_o;

   fill_r #(.ADDR_W(ADDR_W), .ID_W(ID_W), .TID_W(TID_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
      .rvalid_i(rvalid_i), .rready_o(rready_o),
      .rmfifo_aempty_i(rmfifo_aempty_i), .rmfifo_rden_o(rmfifo_rden_o),
      .rmfifo_data_i(rmfifo_data_i),
      .flfifo_afull_i(flfifo_afull_i), .flfifo_wren_o(flfifo_wren_o),
      .flfifo_data_o(flfifo_data_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   logic [TID_W+ADDR_W-1:0] rm_q[$];
   beat_t                   r_q[$];
   logic [FL_W-1:0]         exp_q[$];

   int total = 0, bad = 0;
   int cyc = 0, afull_until = 0;
   int s_cyc, rden_cyc, wren_cyc, prev_wren_cyc, rden_cnt, hs_cnt;
   logic s_wren, s_rready;
   logic [FL_W-1:0] s_data;

   task automatic chk(input string tag, input logic [FL_W-1:0] obs, input logic [FL_W-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      rmfifo_aempty_i = (rm_q.size() == 0);
      rmfifo_data_i   = (rm_q.size() == 0) ? '0 : rm_q[0];
      flfifo_afull_i  = (cyc < afull_until);
      if (r_q.size() > 0) begin
         rvalid_i = 1'b1; rdata_i = r_q[0].d; rid_i = r_q[0].id;
         rresp_i  = r_q[0].resp; rlast_i = r_q[0].last;
      end else begin
         rvalid_i = 1'b0; rdata_i = '0; rid_i = '0; rresp_i = '0; rlast_i = 1'b0;
      end
   endtask

   // One clock: sample at negedge, advance the models just after the posedge.
   task automatic step();
      logic hs, pop_rm;
      @(negedge clk);
      s_cyc    = cyc;
      s_wren   = flfifo_wren_o;
      s_rready = rready_o;
      s_data   = flfifo_data_o;
      hs       = rvalid_i && rready_o;
      pop_rm   = rmfifo_rden_o;
      if (pop_rm) begin rden_cyc = cyc; rden_cnt++; end
      if (hs) hs_cnt++;
      if (s_wren) begin
         prev_wren_cyc = wren_cyc;
         wren_cyc = cyc;
         if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
         else chk("fill_data", s_data, exp_q.pop_front());
      end
      @(posedge clk);
      cyc++;
      #1;
      if (hs && r_q.size() > 0) void'(r_q.pop_front());
      if (pop_rm && rm_q.size() > 0) void'(rm_q.pop_front());
      drive();
   endtask

   task automatic add_fill(input logic [TID_W-1:0] tid, input logic [ADDR_W-1:0] addr,
                           input logic [BEAT_W-1:0] base, input int n, input logic [ID_W-1:0] rid,
                           input int bad_beat, input bit expect_push);
      logic [LINE_W-1:0] line;
      beat_t b;
      line = '0;
      rm_q.push_back({tid, addr});
      for (int k = 0; k < n; k++) begin
         b.d = base + BEAT_W'(k); b.id = rid;
         b.resp = (k == bad_beat) ? 2'b10 : 2'b00;
         b.last = (k == n - 1);
         r_q.push_back(b);
         line[k*BEAT_W +: BEAT_W] = b.d;
      end
      if (expect_push) exp_q.push_back({tid, addr, line});
      drive();
   endtask

   task automatic run_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin step(); n++; end
      if (exp_q.size() > 0) chk({tag, "_timeout"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      int t0, n0, n;
      drive();
      repeat (3) step();
      // reset state
      chk("rst_rready", rready_o, 0);
      chk("rst_rden", rmfifo_rden_o, 0);
      chk("rst_wren", flfifo_wren_o, 0);
      chk("rst_data", flfifo_data_o, 0);
      chk("rst_err", err_o, 0);
      rst = 1'b0;
      step();

      // single fill and its latency
      add_fill(10'd3, 64'h11, 64'h1000, 8, 16'd3, -1, 1'b1);
      run_drain("single", 40);
      chk("single_latency", wren_cyc - rden_cyc, 9);
      chk("single_err", err_o, 0);

      // back-to-back entries with continuous beats
      add_fill(10'd1, 64'h40, 64'h4000, 8, 16'd1, -1, 1'b1);
      add_fill(10'd2, 64'h80, 64'h8000, 8, 16'd2, -1, 1'b1);
      run_drain("b2b", 60);
      chk("b2b_spacing", wren_cyc - prev_wren_cyc, 10);

      // backpressure: afull held five cycles into S_PUSH
      afull_until = 32'h7fff_ffff;
      n0 = rden_cnt;
      add_fill(10'd7, 64'hABC0, 64'h7700, 8, 16'd7, -1, 1'b1);
      n = 0;
      while (rden_cnt == n0 && n < 20) begin step(); n++; end
      chk("bp_pop_seen", rden_cnt - n0, 1);
      t0 = rden_cyc;
      afull_until = t0 + 14;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         step();
         n++;
         if (s_cyc >= t0 + 9 && s_cyc <= t0 + 13) begin
            chk("bp_no_wren", s_wren, 0);
            chk("bp_no_rready", s_rready, 0);
            chk("bp_data_held", s_data, exp_q[0]);
         end
      end
      if (exp_q.size() > 0) chk("bp_timeout", exp_q.size(), 0);
      chk("bp_latency", wren_cyc - t0, 14);

      // early rlast on beat 3, then a normal burst
      add_fill(10'd4, 64'h200, 64'h2000, 4, 16'd4, -1, 1'b1);
      add_fill(10'd6, 64'h300, 64'h3000, 8, 16'd6, -1, 1'b1);
      run_drain("early", 60);
      chk("early_err", err_o, 3'b001);

      // resp and id errors, sticky until reset
      do_reset();
      chk("err_cleared", err_o, 0);
      add_fill(10'd3, 64'h500, 64'h5000, 8, 16'd5, 2, 1'b1);
      run_drain("errs", 40);
      chk("errs_err", err_o, 3'b110);
      add_fill(10'd8, 64'h600, 64'h6000, 8, 16'd8, -1, 1'b1);
      run_drain("errs_clean", 40);
      chk("errs_sticky", err_o, 3'b110);
      do_reset();
      chk("errs_rst", err_o, 0);

      // reset mid-burst after four beats
      n0 = hs_cnt;
      add_fill(10'd9, 64'h900, 64'h9000, 8, 16'd9, 1, 1'b0);
      n = 0;
      while (hs_cnt - n0 < 4 && n < 30) begin step(); n++; end
      chk("mid_beats", hs_cnt - n0, 4);
      rst = 1'b1;
      #1;
      chk("mid_rready", rready_o, 0);
      chk("mid_rden", rmfifo_rden_o, 0);
      chk("mid_wren", flfifo_wren_o, 0);
      chk("mid_data", flfifo_data_o, 0);
      chk("mid_err", err_o, 0);
      r_q.delete();
      rm_q.delete();
      drive();
      repeat (2) step();
      rst = 1'b0;
      step();
      add_fill(10'd12, 64'hC00, 64'hC000, 8, 16'd12, -1, 1'b1);
      run_drain("post_rst", 40);
      chk("post_rst_err", err_o, 0);
      repeat (3) step();
      chk("no_extra_push", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
